// File: rtl/param_sram_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : param_sram_ctrl                                               |
// | Single-port data RAM: byte-lane writes, req/ready handshake, registered  |
// | read with valid strobe, hardware clear sweep after reset.                |
// | Option   : RAM_PARITY_EN adds per-lane even parity and the par_err port. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module param_sram_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic                  ready,
  output logic                  busy,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rdata
`ifdef RAM_PARITY_EN
  ,
  output logic                  par_err
`endif
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr_ptr;
  logic                r_ready;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic w_acc;
  logic w_wr;
  logic w_rd;
  logic w_clr;

  // Reset overrides any access or sweep write presented on the same edge.
  assign w_acc = req && r_ready && !reset;
  assign w_wr  = w_acc && we;
  assign w_rd  = w_acc && !we;
  assign w_clr = (r_state == ST_CLEAR) && !reset;

  assign ready    = r_ready;
  assign busy     = ~r_ready;
  assign rd_valid = r_rd_valid;
  assign rdata    = r_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_CLEAR;
      r_clr_ptr  <= '0;
      r_ready    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) begin
        r_rdata <= r_mem[addr];
      end
      case (r_state)
        ST_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + 1'b1;
          if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_CLEAR;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Sweep and client writes never coincide: ready is low for the whole sweep.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

`ifdef RAM_PARITY_EN
  logic [BE_W-1:0] r_par [DEPTH];
  logic [BE_W-1:0] w_wpar;
  logic [BE_W-1:0] w_rpar;
  logic            r_par_err;

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane_par
    assign w_wpar[gi] = ^wdata[8*gi +: 8];
    assign w_rpar[gi] = ^r_mem[addr][8*gi +: 8];
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_par[r_clr_ptr] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          r_par[addr][i] <= w_wpar[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= w_rd && (|(w_rpar ^ r_par[addr]));
    end
  end

  assign par_err = r_par_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_sram_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_param_sram_ctrl                                            |
// | Randomized bench for param_sram_ctrl against an array-based model.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_param_sram_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [1:0]        be = '0;
  logic              ready;
  logic              busy;
  logic              rd_valid;
  logic [DATA_W-1:0] rdata;
`ifdef RAM_PARITY_EN
  logic              par_err;
`endif

  param_sram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .be       (be),
    .ready    (ready),
    .busy     (busy),
    .rd_valid (rd_valid),
    .rdata    (rdata)
`ifdef RAM_PARITY_EN
    ,
    .par_err  (par_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: word array, remaining sweep cycles, expected outputs.
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic              m_bad [DEPTH];
  int                m_left = DEPTH;
  logic              m_vld = 1'b0;
  logic [DATA_W-1:0] m_rdata = '0;
  logic              m_perr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [1:0] b);
    req = r; we = w; addr = a; wdata = d; be = b;
    @(posedge clk);
    m_vld  = 1'b0;
    m_perr = 1'b0;
    if (reset) begin
      m_left  = DEPTH;
      m_rdata = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          m_mem[i] = '0;
          m_bad[i] = 1'b0;
        end
      end
    end else if (r) begin
      if (w) begin
        for (int l = 0; l < 2; l++) begin
          if (b[l]) m_mem[a][8*l +: 8] = d[8*l +: 8];
        end
        if (b[0]) m_bad[a] = 1'b0;
      end else begin
        m_vld   = 1'b1;
        m_rdata = m_mem[a];
        m_perr  = m_bad[a];
      end
    end
    #1;
    check("ready", {31'd0, ready}, {31'd0, m_left == 0});
    check("busy", {31'd0, busy}, {31'd0, m_left != 0});
    check("rd_valid", {31'd0, rd_valid}, {31'd0, m_vld});
    check("rdata", {16'd0, rdata}, {16'd0, m_rdata});
`ifdef RAM_PARITY_EN
    check("par_err", {31'd0, par_err}, {31'd0, m_perr});
`endif
  endtask

  task automatic rnd_step();
    step(1'($urandom), 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), 2'($urandom));
  endtask

  // Counts cycles from reset release until ready is seen, with random req traffic.
  task automatic sweep_len(input string tag);
    int n;
    n = 0;
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      rnd_step();
      n = k;
      if (ready) break;
    end
    check(tag, n, DEPTH);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, ADDR_W'(i), DATA_W'($urandom), 2'($urandom));
    step(1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_bad[i] = 1'b0;

    // Reset for two cycles with random requests, then time the sweep.
    reset = 1'b1;
    rnd_step();
    rnd_step();
    sweep_len("t1_sweep_len");
    read_all();

    // Full write then partial-lane writes.
    step(1'b1, 1'b1, 3'd5, 16'hBEEF, 2'b11);
    step(1'b1, 1'b0, 3'd5, 16'h0000, 2'b00);
    check("t2_rdata", {16'd0, rdata}, 32'h0000_BEEF);
    step(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00);
    check("t2_hold", {15'd0, rd_valid, rdata}, 32'h0000_BEEF);
    step(1'b1, 1'b1, 3'd5, 16'h1234, 2'b01);
    step(1'b1, 1'b0, 3'd5, 16'h0000, 2'b00);
    check("t3_lane0", {16'd0, rdata}, 32'h0000_BE34);
    step(1'b1, 1'b1, 3'd5, 16'hFFFF, 2'b00);
    step(1'b1, 1'b0, 3'd5, 16'h0000, 2'b00);
    check("t3_be0", {16'd0, rdata}, 32'h0000_BE34);

    // Fill every address, then read back-to-back.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, ADDR_W'(i), DATA_W'($urandom), 2'b11);
    read_all();

    for (int k = 0; k < 400; k++) rnd_step();

    // Reset on the 4th sweep cycle with requests pending.
    reset = 1'b1;
    rnd_step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) rnd_step();
    reset = 1'b1;
    step(1'b1, 1'b1, 3'd1, 16'hA5A5, 2'b11);
    sweep_len("t5_sweep_len");
    read_all();

    // Reset in the cycle right after an accepted read squashes rd_valid.
    step(1'b1, 1'b0, 3'd2, 16'h0000, 2'b00);
    reset = 1'b1;
    step(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00);
    check("squash_rd_valid", {31'd0, rd_valid}, 32'd0);
    sweep_len("sweep_after_squash");

`ifdef RAM_PARITY_EN
    step(1'b1, 1'b1, 3'd2, 16'h00FF, 2'b11);
    step(1'b1, 1'b1, 3'd3, 16'h0F0F, 2'b11);
    dut.r_mem[2][0] = ~dut.r_mem[2][0];
    m_mem[2][0] = ~m_mem[2][0];
    m_bad[2] = 1'b1;
    step(1'b1, 1'b0, 3'd2, 16'h0000, 2'b00);
    check("t6_par_err_bad", {30'd0, par_err, rd_valid}, 32'd3);
    step(1'b1, 1'b0, 3'd3, 16'h0000, 2'b00);
    check("t6_par_err_clean", {30'd0, par_err, rd_valid}, 32'd1);
`endif

    for (int k = 0; k < 200; k++) rnd_step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
